// File: rtl/trick_lock_pkg.sv
// Shared types and constants for the trick-lock verify block (state encoding, digit type, reset password).
package trick_lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ERROR  = 3'd2,
        ST_OPEN   = 3'd3,
        ST_ALARM  = 3'd4
    } lock_state_t;

    typedef logic [3:0] digit_t;

    localparam logic [15:0] DEFAULT_PW = 16'h1234;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trick_lock_verify_lock_timer.sv
// lock_timer: loadable down-counter with a zero flag, shared by the alarm lockout and open timeouts.
module lock_timer
    import trick_lock_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/trick_lock_verify.sv
// Password check / alarm lockout / password change for the trick lock.
// Optional macro TRICK_LOCK_AUTO_RELOCK_EN enables the OPEN auto-relock timeout.
module trick_lock_verify
    import trick_lock_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned OPEN_CYCLES    = 500,
    parameter logic [15:0] DEFAULT_PW     = trick_lock_pkg::DEFAULT_PW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       confirm,
    input  logic       lockkey,
    input  logic       change_pw,
    input  digit_t     pw0,
    input  digit_t     pw1,
    input  digit_t     pw2,
    input  digit_t     pw3,
    output logic       unlocked,
    output logic       err,
    output logic       alarm,
    output logic       pw_saved,
    output logic [1:0] tries_left
);

    localparam int unsigned TIMER_W = $clog2(max_u(LOCKOUT_CYCLES, OPEN_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
`endif
    localparam logic [1:0] MAX_TRIES_L = 2'(MAX_TRIES);

    lock_state_t        state_q, state_d;
    logic [15:0]        stored_pw_q, stored_pw_d;
    logic [15:0]        entry_q, entry_d;
    logic [1:0]         fail_cnt_q, fail_cnt_d;
    logic               unlocked_q, unlocked_d;
    logic               err_q, err_d;
    logic               alarm_q, alarm_d;
    logic               pw_saved_q, pw_saved_d;
    logic [1:0]         tries_left_q, tries_left_d;

    logic [15:0]        pw_in;
    logic [1:0]         fail_next;
    logic               save_evt;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_value;
    logic               timer_en;
    logic               timer_zero;

    assign pw_in     = {pw3, pw2, pw1, pw0};
    assign fail_next = (fail_cnt_q == MAX_TRIES_L) ? fail_cnt_q : fail_cnt_q + 2'd1;

    always_comb begin
        state_d          = state_q;
        stored_pw_d      = stored_pw_q;
        entry_d          = entry_q;
        fail_cnt_d       = fail_cnt_q;
        save_evt         = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = '0;
        timer_en         = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (confirm) begin
                    entry_d = pw_in;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (entry_q == stored_pw_q) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = '0;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                    timer_load       = 1'b1;
                    timer_load_value = OPEN_LOAD;
`endif
                end else begin
                    fail_cnt_d = fail_next;
                    if (fail_next == MAX_TRIES_L) begin
                        state_d          = ST_ALARM;
                        timer_load       = 1'b1;
                        timer_load_value = LOCKOUT_LOAD;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end

            ST_ERROR: begin
                state_d = ST_LOCKED;
            end

            // lockkey beats both the timeout and a same-cycle save request.
            ST_OPEN: begin
                if (lockkey) begin
                    state_d = ST_LOCKED;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                end else if (timer_zero) begin
                    state_d = ST_LOCKED;
`endif
                end else if (confirm && change_pw) begin
                    stored_pw_d = pw_in;
                    save_evt    = 1'b1;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                    timer_load       = 1'b1;
                    timer_load_value = OPEN_LOAD;
`endif
                end else begin
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                    timer_en = 1'b1;
`endif
                end
            end

            ST_ALARM: begin
                if (timer_zero) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = '0;
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    // Indications follow the state held during the cycle, one edge later.
    always_comb begin
        unlocked_d   = (state_q == ST_OPEN);
        err_d        = (state_q == ST_ERROR);
        alarm_d      = (state_q == ST_ALARM);
        pw_saved_d   = save_evt;
        tries_left_d = MAX_TRIES_L - fail_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOCKED;
            stored_pw_q  <= DEFAULT_PW;
            entry_q      <= '0;
            fail_cnt_q   <= '0;
            unlocked_q   <= 1'b0;
            err_q        <= 1'b0;
            alarm_q      <= 1'b0;
            pw_saved_q   <= 1'b0;
            tries_left_q <= MAX_TRIES_L;
        end else begin
            state_q      <= state_d;
            stored_pw_q  <= stored_pw_d;
            entry_q      <= entry_d;
            fail_cnt_q   <= fail_cnt_d;
            unlocked_q   <= unlocked_d;
            err_q        <= err_d;
            alarm_q      <= alarm_d;
            pw_saved_q   <= pw_saved_d;
            tries_left_q <= tries_left_d;
        end
    end

    lock_timer #(
        .W (TIMER_W)
    ) u_lock_timer (
        .clk        (clk),
        .rst_n      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .en         (timer_en),
        .zero       (timer_zero)
    );

    assign unlocked   = unlocked_q;
    assign err        = err_q;
    assign alarm      = alarm_q;
    assign pw_saved   = pw_saved_q;
    assign tries_left = tries_left_q;

endmodule

// File: tb/tb_trick_lock_verify.sv
// Directed bench for trick_lock_verify: timeline model of the lock plus literal spot checks.
module tb_trick_lock_verify;

    localparam int MAX = 3;
    localparam int LCK = 1000;
    localparam int OPN = 500;
    localparam int FAR = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       reset;
    logic       confirm, lockkey, change_pw;
    logic [3:0] pw0, pw1, pw2, pw3;
    logic       unlocked, err, alarm, pw_saved;
    logic [1:0] tries_left;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    trick_lock_verify #(
        .MAX_TRIES      (MAX),
        .LOCKOUT_CYCLES (LCK),
        .OPEN_CYCLES    (OPN),
        .DEFAULT_PW     (16'h1234)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .confirm    (confirm),
        .lockkey    (lockkey),
        .change_pw  (change_pw),
        .pw0        (pw0),
        .pw1        (pw1),
        .pw2        (pw2),
        .pw3        (pw3),
        .unlocked   (unlocked),
        .err        (err),
        .alarm      (alarm),
        .pw_saved   (pw_saved),
        .tries_left (tries_left)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Timeline model: each accepted confirm is resolved at once and its visible
    // effects are recorded as edge numbers at which the outputs change.
    int          k, accept_from, open_from, unl_lo, unl_hi, err_at, alarm_lo, alarm_hi;
    int          t1_at, t1_val, t2_at, t2_val, m_fails;
    bit          is_open;
    logic [15:0] m_pw;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
    int          relock_at;
`endif
    logic        e_unl, e_err, e_alarm, e_saved;
    int          e_tries;

    task automatic model_reset();
        k = 0; accept_from = 1; open_from = FAR; is_open = 1'b0;
        unl_lo = 1; unl_hi = 0; err_at = -1; alarm_lo = 1; alarm_hi = 0;
        t1_at = -1; t1_val = 0; t2_at = -1; t2_val = 0; m_fails = 0;
        m_pw = 16'h1234;
        e_unl = 1'b0; e_err = 1'b0; e_alarm = 1'b0; e_saved = 1'b0; e_tries = MAX;
    endtask

    task automatic model_relock();
        is_open = 1'b0; unl_hi = k; accept_from = k + 1;
    endtask

    task automatic model_step();
        logic [15:0] pw;
        pw = {pw3, pw2, pw1, pw0};
        k++;
        e_saved = 1'b0;
        if (is_open) begin
            if (k >= open_from) begin
                if (lockkey) model_relock();
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                else if (k == relock_at) model_relock();
`endif
                else if (confirm && change_pw) begin
                    m_pw = pw; e_saved = 1'b1;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                    relock_at = k + OPN;
`endif
                end
            end
        end else if (k >= accept_from && confirm) begin
            t2_at = -1;
            if (pw == m_pw) begin
                is_open = 1'b1; open_from = k + 2; unl_lo = k + 2; unl_hi = FAR;
                m_fails = 0; t1_at = k + 2; t1_val = MAX;
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
                relock_at = k + 1 + OPN;
`endif
            end else begin
                m_fails = (m_fails < MAX) ? m_fails + 1 : MAX;
                t1_at = k + 2; t1_val = MAX - m_fails;
                if (m_fails == MAX) begin
                    alarm_lo = k + 2; alarm_hi = k + 1 + LCK; accept_from = k + LCK + 2;
                    m_fails = 0; t2_at = k + LCK + 2; t2_val = MAX;
                end else begin
                    err_at = k + 2; accept_from = k + 3;
                end
            end
        end
        if (k == t1_at) e_tries = t1_val;
        if (k == t2_at) e_tries = t2_val;
        e_unl   = (k >= unl_lo) && (k <= unl_hi);
        e_err   = (k == err_at);
        e_alarm = (k >= alarm_lo) && (k <= alarm_hi);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_unlocked", int'(unlocked), int'(e_unl));
            check("cmp_err", int'(err), int'(e_err));
            check("cmp_alarm", int'(alarm), int'(e_alarm));
            check("cmp_pw_saved", int'(pw_saved), int'(e_saved));
            check("cmp_tries_left", int'(tries_left), e_tries);
        end
    end

    task automatic cyc(input logic c, input logic lk, input logic ch, input logic [15:0] v);
        confirm = c; lockkey = lk; change_pw = ch;
        {pw3, pw2, pw1, pw0} = v;
        @(negedge clk);
        confirm = 1'b0; lockkey = 1'b0; change_pw = 1'b0;
    endtask

    task automatic run_count(input int n, output int cu, output int ce, output int ca, output int cs);
        cu = 0; ce = 0; ca = 0; cs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cu += int'(unlocked); ce += int'(err); ca += int'(alarm); cs += int'(pw_saved);
        end
    endtask

    task automatic enter(input logic [15:0] v, output int cu, output int ce);
        int ca, cs;
        cyc(1'b1, 1'b0, 1'b0, v);
        run_count(3, cu, ce, ca, cs);
    endtask

    task automatic relock();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cu, ce, ca, cs, acnt;
        reset = 1'b0; confirm = 1'b0; lockkey = 1'b0; change_pw = 1'b0;
        {pw3, pw2, pw1, pw0} = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_tries", int'(tries_left), 3);
        cmp_en = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Correct code: unlocked rises after edge N+2.
        cyc(1'b1, 1'b0, 1'b0, 16'h1234);
        @(negedge clk);
        check("open_after_n1", int'(unlocked), 0);
        @(negedge clk);
        check("open_after_n2", int'(unlocked), 1);
        check("open_tries", int'(tries_left), 3);
        check("open_err", int'(err), 0);
        relock();
        check("relock_unlocked", int'(unlocked), 0);

        // Single failure.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        run_count(6, cu, ce, ca, cs);
        check("fail1_err_pulses", ce, 1);
        check("fail1_unlocked", cu, 0);
        check("fail1_tries", int'(tries_left), 2);

        // Clear the fail count, then three wrong entries into a lockout.
        enter(16'h1234, cu, ce);
        relock();
        enter(16'h1111, cu, ce);
        check("lk_tries_2", int'(tries_left), 2);
        enter(16'h2222, cu, ce);
        check("lk_tries_1", int'(tries_left), 1);
        cyc(1'b1, 1'b0, 1'b0, 16'h3333);
        acnt = 0;
        for (int i = 0; i < 1200; i++) begin
            cyc(((i % 97) == 5) && (i < 900), 1'b0, 1'b0, 16'h1234);
            acnt += int'(alarm);
        end
        check("lk_alarm_width", acnt, 1000);
        check("lk_tries_after", int'(tries_left), 3);
        check("lk_unlocked_after", int'(unlocked), 0);

        // Change password.
        enter(16'h1234, cu, ce);
        cyc(1'b1, 1'b0, 1'b1, 16'h9A5F);
        check("chg_pw_saved", int'(pw_saved), 1);
        run_count(3, cu, ce, ca, cs);
        check("chg_saved_once", cs, 0);
        relock();
        enter(16'h9A5F, cu, ce);
        check("chg_new_opens", int'(unlocked), 1);
        relock();
        enter(16'h9A5E, cu, ce);
        check("chg_digit_e_err", ce, 1);
        enter(16'h1234, cu, ce);
        check("chg_old_err", ce, 1);
        check("chg_old_unlocked", cu, 0);

        // lockkey beats a same-cycle save.
        enter(16'h9A5F, cu, ce);
        cyc(1'b1, 1'b1, 1'b1, 16'h5555);
        check("prio_no_save", int'(pw_saved), 0);
        repeat (2) @(negedge clk);
        check("prio_locked", int'(unlocked), 0);
        enter(16'h5555, cu, ce);
        check("prio_5555_err", ce, 1);
        enter(16'h9A5F, cu, ce);
        check("prio_pw_kept", cu, 2);
        relock();

        // Reset in the middle of a lockout.
        enter(16'h0001, cu, ce);
        enter(16'h0002, cu, ce);
        cyc(1'b1, 1'b0, 1'b0, 16'h0003);
        for (int i = 0; i < 10; i++) if (!alarm) @(negedge clk);
        repeat (499) @(negedge clk);
        check("mid_alarm_high", int'(alarm), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_alarm", int'(alarm), 0);
        check("mid_rst_tries", int'(tries_left), 3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        enter(16'h9A5F, cu, ce);
        check("mid_rst_custom_gone", ce, 1);
        enter(16'h1234, cu, ce);
        check("mid_rst_default_pw", cu, 2);

        // Open-state duration from a fresh open.
        relock();
        cyc(1'b1, 1'b0, 1'b0, 16'h1234);
        run_count(700, cu, ce, ca, cs);
`ifdef TRICK_LOCK_AUTO_RELOCK_EN
        check("open_duration", cu, 500);
`else
        check("open_duration", cu, 699);
`endif

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trick_lock_verify.md
Name: trick_lock_verify

Overview:
- Consumer side of the 4-digit keypad entry block: samples the entered digits pw0..pw3 on a confirm strobe and compares them with a stored 16-bit password.
- Drives the unlock, error and alarm indications of the trick-lock top level.
- Counts consecutive failures and enforces a timed alarm lockout.
- While open, allows the stored password to be replaced by the current entry.

Parameters:
- MAX_TRIES, 3: consecutive failed checks that trigger the alarm (range 1..3).
- LOCKOUT_CYCLES, 1000: clk cycles the alarm state is held.
- OPEN_CYCLES, 500: auto-relock timeout in clk cycles (only used with AUTO_RELOCK_EN).
- DEFAULT_PW, 16'h1234: stored password after reset, ordered {pw3,pw2,pw1,pw0}.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- confirm  input  1  one-cycle strobe: entry complete, sample pw0..pw3.
- lockkey  input  1  relock request (level).
- change_pw  input  1  qualifies confirm in OPEN as a password update.
- pw0, pw1, pw2, pw3  input  4 each  entered digits from the keypad block.
- unlocked  output  1  high while state is OPEN.
- err  output  1  one-cycle pulse on a non-final failed check.
- alarm  output  1  high while state is ALARM.
- pw_saved  output  1  one-cycle pulse when a new password is stored.
- tries_left  output  2  MAX_TRIES minus fail count.

Behaviour:
- Reset (async, reset=0):
  - state = LOCKED, stored_pw = DEFAULT_PW, fail_cnt = 0, timer = 0.
  - unlocked/err/alarm/pw_saved = 0, tries_left = MAX_TRIES.
  - A reset asserted mid-check, mid-lockout or while open aborts to these values immediately.
- States: LOCKED, CHECK, ERROR, OPEN, ALARM. Outputs are registered; each one reflects the state it is set with.
- LOCKED:
  - confirm=1 captures {pw3,pw2,pw1,pw0} into entry_q and moves to CHECK.
  - lockkey and change_pw are ignored.
- CHECK (exactly one cycle):
  - entry_q == stored_pw: go to OPEN and clear fail_cnt.
  - Mismatch: fail_cnt+1; if the new count equals MAX_TRIES go to ALARM, else go to ERROR.
  - Latency: confirm sampled at edge N gives unlocked/err/alarm high after edge N+2.
- ERROR (exactly one cycle): err=1, then return to LOCKED. confirm is ignored.
- OPEN:
  - unlocked=1.
  - lockkey=1: go to LOCKED at the next edge.
  - confirm=1 with change_pw=1 and lockkey=0: stored_pw <= current {pw3..pw0}, pw_saved pulses one cycle, stay in OPEN.
  - confirm without change_pw: ignored.
  - lockkey and confirm in the same cycle: lockkey wins and no save occurs.
- ALARM:
  - alarm=1; timer loads LOCKOUT_CYCLES-1 on entry and decrements each cycle.
  - Timer at 0: go to LOCKED and clear fail_cnt. Alarm width is exactly LOCKOUT_CYCLES cycles.
  - confirm, lockkey and change_pw are ignored.
- Counters:
  - fail_cnt saturates at MAX_TRIES.
  - tries_left = MAX_TRIES - fail_cnt, and equals 0 in ALARM.
  - timer width is $clog2(max(LOCKOUT_CYCLES, OPEN_CYCLES)+1).
- Only confirm edges are meaningful; pw inputs are don't-care otherwise. Equality is bitwise over all 16 bits, so digits A–F compare as distinct values.

Optional Feature:
- Macro: TRICK_LOCK_AUTO_RELOCK_EN.
- Defined:
  - On entry to OPEN the timer loads OPEN_CYCLES-1 and decrements each cycle; at 0 the block goes to LOCKED.
  - A pw_saved event reloads the timer.
  - lockkey still relocks early.
- Undefined: OPEN persists until lockkey; the timer is used only for ALARM.

Decomposition:
- Package trick_lock_pkg holds:
  - state enum typedef (lock_state_t, 3-bit encoding);
  - DEFAULT_PW constant;
  - the digit typedef (4-bit).
- One sub-module, lock_timer: loadable down-counter with load, load_value, enable and a zero flag. It is shared by the ALARM and OPEN timeouts.

Test Plan:
- Correct code: reset, pw={4,3,2,1} (stored 16'h1234 as {pw3..pw0}={1,2,3,4}), confirm at edge N -> unlocked=1 from edge N+2, tries_left=3, err=0.
- Single failure: pw=16'h0000, confirm -> err pulses exactly one cycle, tries_left=2, state returns to LOCKED, unlocked stays 0.
- Lockout: three wrong confirms -> alarm=1 for exactly 1000 cycles, confirms during the alarm are ignored, then state is LOCKED with tries_left=3.
- Change password: in OPEN, change_pw=1, pw=16'h9A5F, confirm -> pw_saved pulse; lockkey; re-enter 16'h9A5F -> unlocked; 16'h1234 -> err.
- Priority: in OPEN, lockkey=1 and confirm=1 with change_pw=1 in the same cycle -> LOCKED, no pw_saved, stored password unchanged.
- Reset mid-operation: reset=0 during ALARM cycle 500 -> alarm=0 immediately; stored_pw=16'h1234 and tries_left=3 after release. With TRICK_LOCK_AUTO_RELOCK_EN, unlocked drops exactly 500 cycles after entering OPEN.
